// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back controller.
// Holds the FSM state encoding, ALU opcode constants and default widths.
// Imported by regfile_wb_ctrl and regfile_wb_fsm.
package regfile_pkg;

  localparam int unsigned OP_W_DEF = 3;
  localparam int unsigned AW_DEF   = 2;
  localparam int unsigned DW_DEF   = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_wb_fsm.sv
// Sequencing FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE, one op per 4 cycles.
// Latency: state outputs are decoded combinationally from the state register.
// Backpressure: in_ready_o is high only in IDLE; the accept is valid&&ready.
module regfile_wb_fsm
  import regfile_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   in_valid_i,
  input  logic   wb_i,
  input  logic   wr_block_i,
  output logic   in_ready_o,
  output logic   wr_en_o,
  output logic   done_o,
  output state_e state_o
);

  state_e state_q, state_d;

  // State register; async reset returns to IDLE, discarding any in-flight op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: a fixed four-step walk, leaving IDLE only on an accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid_i) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: write strobe and done only ever appear in WRITE.
  always_comb begin
    in_ready_o = (state_q == ST_IDLE);
    done_o     = (state_q == ST_WRITE);
    wr_en_o    = (state_q == ST_WRITE) && wb_i && !wr_block_i;
  end

  assign state_o = state_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: latch op, drive datapath, write {ovf,f}.
// Latency: accept at edge N, write/done in the cycle after edge N+2, ready after N+3.
// Backpressure: in_ready is low for the 3 busy cycles; throughput 1 op per 4 cycles.
// Optional feature macro: REGFILE_WB_OVF_TRAP_EN (suppress write on ovf, sticky ovf_err).
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [AW-1:0]   in_rs0,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_src1,
  input  logic            in_src2,
  input  logic [DW-1:0]   in_imm,
  input  logic            in_wb,
  output logic [AW-1:0]   rd0_addr,
  output logic [AW-1:0]   rd1_addr,
  output logic            alu_src1,
  output logic            alu_src2,
  output logic [OP_W-1:0] alu_op,
  output logic [DW-1:0]   imm_o,
  input  logic [DW-1:0]   alu_f,
  input  logic            alu_ovf,
  input  logic            alu_br,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW:0]     wr_data,
  output logic            done,
`ifdef REGFILE_WB_OVF_TRAP_EN
  output logic            ovf_err,
`endif
  output logic            br_flag
);

  state_e state;
  logic   accept;
  logic   wr_block;

  logic [OP_W-1:0] op_q,   op_d;
  logic [AW-1:0]   rs0_q,  rs0_d;
  logic [AW-1:0]   rs1_q,  rs1_d;
  logic [AW-1:0]   rd_q,   rd_d;
  logic            src1_q, src1_d;
  logic            src2_q, src2_d;
  logic [DW-1:0]   imm_q,  imm_d;
  logic            wb_q,   wb_d;
  logic [DW-1:0]   f_q,    f_d;
  logic            ovf_q,  ovf_d;
  logic            br_q,   br_d;

  assign accept = in_valid && in_ready;

`ifdef REGFILE_WB_OVF_TRAP_EN
  logic ovf_err_q, ovf_err_d;
  assign wr_block = ovf_q;
  assign ovf_err  = ovf_err_q;

  // Sticky overflow error: set by any overflowing op reaching WRITE.
  always_comb begin
    ovf_err_d = ovf_err_q;
    if (state == ST_WRITE && ovf_q) ovf_err_d = 1'b1;
  end

  // Overflow error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_err_q <= 1'b0;
    else      ovf_err_q <= ovf_err_d;
  end
`else
  assign wr_block = 1'b0;
`endif

  regfile_wb_fsm u_fsm (
    .clk_i      (clk),
    .rst_ni     (rst),
    .in_valid_i (in_valid),
    .wb_i       (wb_q),
    .wr_block_i (wr_block),
    .in_ready_o (in_ready),
    .wr_en_o    (wr_en),
    .done_o     (done),
    .state_o    (state)
  );

  // Field latches: load only on the accept cycle, so later in_* changes are ignored.
  always_comb begin
    op_d   = op_q;
    rs0_d  = rs0_q;
    rs1_d  = rs1_q;
    rd_d   = rd_q;
    src1_d = src1_q;
    src2_d = src2_q;
    imm_d  = imm_q;
    wb_d   = wb_q;
    if (accept) begin
      op_d   = in_op;
      rs0_d  = in_rs0;
      rs1_d  = in_rs1;
      rd_d   = in_rd;
      src1_d = in_src1;
      src2_d = in_src2;
      imm_d  = in_imm;
      wb_d   = in_wb;
    end
  end

  // Result capture: the ALU is sampled once, on the EXEC->WRITE edge.
  always_comb begin
    f_d   = f_q;
    ovf_d = ovf_q;
    br_d  = br_q;
    if (state == ST_EXEC) begin
      f_d   = alu_f;
      ovf_d = alu_ovf;
      br_d  = alu_br;
    end
  end

  // Field and result registers; reset clears every datapath-facing output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      rs0_q  <= '0;
      rs1_q  <= '0;
      rd_q   <= '0;
      src1_q <= 1'b0;
      src2_q <= 1'b0;
      imm_q  <= '0;
      wb_q   <= 1'b0;
      f_q    <= '0;
      ovf_q  <= 1'b0;
      br_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      rs0_q  <= rs0_d;
      rs1_q  <= rs1_d;
      rd_q   <= rd_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      imm_q  <= imm_d;
      wb_q   <= wb_d;
      f_q    <= f_d;
      ovf_q  <= ovf_d;
      br_q   <= br_d;
    end
  end

  // Datapath drive straight from the latches: stable from READ through WRITE.
  always_comb begin
    rd0_addr = rs0_q;
    rd1_addr = rs1_q;
    alu_src1 = src1_q;
    alu_src2 = src2_q;
    alu_op   = op_q;
    imm_o    = imm_q;
    wr_addr  = rd_q;
    wr_data  = {ovf_q, f_q};
    br_flag  = br_q;
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = 3'd0;
  logic [1:0] in_rs0 = 2'd0, in_rs1 = 2'd0, in_rd = 2'd0;
  logic       in_src1 = 1'b0, in_src2 = 1'b0;
  logic [7:0] in_imm = 8'd0;
  logic       in_wb = 1'b0;
  logic [1:0] rd0_addr, rd1_addr;
  logic       alu_src1, alu_src2;
  logic [2:0] alu_op;
  logic [7:0] imm_o;
  logic [7:0] alu_f;
  logic       alu_ovf, alu_br;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [8:0] wr_data;
  logic       done;
  logic       br_flag;
`ifdef REGFILE_WB_OVF_TRAP_EN
  logic       ovf_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd),
    .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm), .in_wb(in_wb),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_op(alu_op), .imm_o(imm_o),
    .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_br(alu_br),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
`ifdef REGFILE_WB_OVF_TRAP_EN
    .ovf_err(ovf_err),
`endif
    .br_flag(br_flag)
  );

  // Datapath environment: 4-entry register file, source muxes, 8-bit ALU.
  logic [8:0] rf [4] = '{9'h055, 9'h0AA, 9'h000, 9'h000};
  logic [7:0] a_op, b_op;

  always @(negedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  always_comb begin
    a_op    = alu_src1 ? rf[rd0_addr][7:0] : 8'h00;
    b_op    = alu_src2 ? rf[rd1_addr][7:0] : imm_o;
    alu_f   = a_op & b_op;
    alu_ovf = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_f   = a_op + b_op;
        alu_ovf = (a_op[7] == b_op[7]) && (alu_f[7] != a_op[7]);
      end
      3'b001: begin
        alu_f   = a_op - b_op;
        alu_ovf = (a_op[7] != b_op[7]) && (alu_f[7] != a_op[7]);
      end
      default: ;
    endcase
    alu_br = (alu_f == 8'h00);
  end

  // Issue one op and sample the four following cycles (bit i = cycle N+1+i).
  task automatic run_op(input logic [2:0] op, input logic [1:0] rs0, input logic [1:0] rs1,
                        input logic [1:0] rd, input logic s1, input logic s2,
                        input logic [7:0] imm, input logic wb,
                        output logic [3:0] wen, output logic [3:0] dn,
                        output logic [1:0] wa, output logic [8:0] wd,
                        output logic br, output logic rdy4);
    int guard = 0;
    wen = '0; dn = '0; wa = '0; wd = '0; br = 1'b0; rdy4 = 1'b0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      fails++;
      $display("FAIL issue_wait: in_ready=%0b required 1 within 20 cycles", in_ready);
    end
    in_op = op; in_rs0 = rs0; in_rs1 = rs1; in_rd = rd;
    in_src1 = s1; in_src2 = s2; in_imm = imm; in_wb = wb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = ~op; in_rs0 = ~rs0; in_rs1 = ~rs1; in_rd = ~rd;
    in_src1 = ~s1; in_src2 = ~s2; in_imm = 8'hEE; in_wb = ~wb;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wen[i] = wr_en;
      dn[i]  = done;
      if (i == 2) begin wa = wr_addr; wd = wr_data; br = br_flag; end
      if (i == 3) rdy4 = in_ready;
    end
  endtask

  task automatic test_reset();
    logic [33:0] outs;
    #1;
    outs = {rd0_addr, rd1_addr, alu_src1, alu_src2, alu_op, imm_o, wr_en, wr_addr, wr_data, done, br_flag};
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    tests++;
    if (outs !== 34'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
`ifdef REGFILE_WB_OVF_TRAP_EN
    tests++;
    if (ovf_err !== 1'b0) begin fails++; $display("FAIL reset_ovf_err: got %0b want 0", ovf_err); end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load();
    logic [3:0] wen, dn; logic [1:0] wa; logic [8:0] wd; logic br, rdy4;
    run_op(3'b000, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 8'd40, 1'b1, wen, dn, wa, wd, br, rdy4);
    tests++;
    if (wen !== 4'b0100) begin fails++; $display("FAIL load_wr_en: got %b want 0100", wen); end
    tests++;
    if (wa !== 2'd2 || wd !== 9'd40) begin fails++; $display("FAIL load_write: got addr %0d data %h want 2 028", wa, wd); end
    tests++;
    if (rdy4 !== 1'b1) begin fails++; $display("FAIL load_ready_n4: got %0b want 1", rdy4); end
    tests++;
    if (rf[2] !== 9'd40) begin fails++; $display("FAIL load_rf: got %h want 028", rf[2]); end
  endtask

  task automatic test_reg_add();
    logic [3:0] wen, dn; logic [1:0] wa; logic [8:0] wd; logic br, rdy4;
    run_op(3'b000, 2'd0, 2'd1, 2'd3, 1'b1, 1'b1, 8'h00, 1'b1, wen, dn, wa, wd, br, rdy4);
    tests++;
    if (wd !== 9'h0FF || wa !== 2'd3) begin fails++; $display("FAIL add_write: got addr %0d data %h want 3 0ff", wa, wd); end
    tests++;
    if (dn !== 4'b0100) begin fails++; $display("FAIL add_done_once: got %b want 0100", dn); end
  endtask

  task automatic test_overflow();
    logic [3:0] wen, dn; logic [1:0] wa; logic [8:0] wd; logic br, rdy4;
    run_op(3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h7F, 1'b1, wen, dn, wa, wd, br, rdy4);
    tests++;
    if (rf[0] !== 9'h07F) begin fails++; $display("FAIL ovf_preload: got %h want 07f", rf[0]); end
    run_op(3'b000, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 8'h01, 1'b1, wen, dn, wa, wd, br, rdy4);
    tests++;
    if (wd !== 9'h180) begin fails++; $display("FAIL ovf_data: got %h want 180", wd); end
    tests++;
    if (dn !== 4'b0100) begin fails++; $display("FAIL ovf_done: got %b want 0100", dn); end
`ifdef REGFILE_WB_OVF_TRAP_EN
    tests++;
    if (wen !== 4'b0000) begin fails++; $display("FAIL ovf_trap_wr_en: got %b want 0000", wen); end
    tests++;
    if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %0b want 1", ovf_err); end
    tests++;
    if (rf[1] !== 9'h0AA) begin fails++; $display("FAIL ovf_trap_rf: got %h want 0aa", rf[1]); end
`else
    tests++;
    if (wen !== 4'b0100) begin fails++; $display("FAIL ovf_wr_en: got %b want 0100", wen); end
    tests++;
    if (rf[1] !== 9'h180) begin fails++; $display("FAIL ovf_rf: got %h want 180", rf[1]); end
`endif
  endtask

  task automatic test_compare();
    logic [3:0] wen, dn; logic [1:0] wa; logic [8:0] wd; logic br, rdy4;
    run_op(3'b001, 2'd2, 2'd2, 2'd3, 1'b1, 1'b1, 8'h00, 1'b0, wen, dn, wa, wd, br, rdy4);
    tests++;
    if (wen !== 4'b0000) begin fails++; $display("FAIL cmp_wr_en: got %b want 0000", wen); end
    tests++;
    if (dn !== 4'b0100) begin fails++; $display("FAIL cmp_done: got %b want 0100", dn); end
    tests++;
    if (br !== 1'b1) begin fails++; $display("FAIL cmp_br_flag: got %0b want 1", br); end
    tests++;
    if (rf[3] !== 9'h0FF) begin fails++; $display("FAIL cmp_rf_untouched: got %h want 0ff", rf[3]); end
  endtask

  task automatic test_reset_mid_exec();
    logic [33:0] outs;
    logic        saw_wen = 1'b0;
    int          guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    in_op = 3'b000; in_rs0 = 2'd0; in_rs1 = 2'd0; in_rd = 2'd3;
    in_src1 = 1'b0; in_src2 = 1'b0; in_imm = 8'd99; in_wb = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    outs = {rd0_addr, rd1_addr, alu_src1, alu_src2, alu_op, imm_o, wr_en, wr_addr, wr_data, done, br_flag};
    tests++;
    if (outs !== 34'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midreset_outputs: got %h ready %0b want 0 ready 1", outs, in_ready);
    end
`ifdef REGFILE_WB_OVF_TRAP_EN
    tests++;
    if (ovf_err !== 1'b0) begin fails++; $display("FAIL midreset_ovf_err: got %0b want 0", ovf_err); end
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_wen = saw_wen | wr_en;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_wen = saw_wen | wr_en;
    end
    tests++;
    if (saw_wen !== 1'b0) begin fails++; $display("FAIL midreset_wr_en: got %0b want 0", saw_wen); end
    tests++;
    if (rf[3] !== 9'h0FF) begin fails++; $display("FAIL midreset_rf: got %h want 0ff", rf[3]); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops_s1 [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0] ops_rs0[3] = '{2'd0, 2'd0, 2'd1};
    logic [1:0] ops_rd [3] = '{2'd0, 2'd1, 2'd2};
    logic       ops_s2 [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] ops_imm[3] = '{8'd5, 8'd3, 8'd0};
    int acc[3] = '{0, 0, 0};
    int n = 0;
    int cyc = 0;
    logic rdy;
    @(negedge clk);
    in_op = 3'b000; in_rs1 = 2'd0; in_wb = 1'b1;
    in_src1 = ops_s1[0][0]; in_rs0 = ops_rs0[0]; in_rd = ops_rd[0];
    in_src2 = ops_s2[0]; in_imm = ops_imm[0]; in_valid = 1'b1;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      cyc++;
      if (rdy) begin
        acc[n] = cyc;
        n++;
        #1;
        if (n < 3) begin
          in_src1 = ops_s1[n][0]; in_rs0 = ops_rs0[n]; in_rd = ops_rd[n];
          in_src2 = ops_s2[n]; in_imm = ops_imm[n];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    repeat (4) @(negedge clk);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d want 3 within 40 cycles", n); end
    tests++;
    if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      fails++; $display("FAIL b2b_spacing: got %0d %0d want 4 4", acc[1] - acc[0], acc[2] - acc[1]);
    end
    tests++;
    if (rf[0] !== 9'd5 || rf[1] !== 9'd8 || rf[2] !== 9'd13) begin
      fails++; $display("FAIL b2b_results: got %h %h %h want 005 008 00d", rf[0], rf[1], rf[2]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_reg_add();
    test_overflow();
    test_compare();
    test_reset_mid_exec();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Sequencing controller that drives the register-file side of the 8-bit datapath. It accepts one decoded operation per handshake, then issues the register-file read addresses, ALU source-mux selects, opcode and immediate. It captures the ALU result and ovf, and writes `{ovf, f}` back to the register file's write port. It sits between instruction decode and the `reg_file`/`Mux8Bit2to1`/`EightbitALU` datapath, as the writer and initiator of that storage.

## Interface
- `OP_W`, 3: ALU opcode width (`ALUOp`).
- `AW`, 2: register address width.
- `DW`, 8: ALU operand/result width; write data is `DW+1`.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation fields valid.
- `in_ready` out 1: controller idle, can accept.
- `in_op` in OP_W: ALU opcode.
- `in_rs0`, `in_rs1`, `in_rd` in AW: source 0, source 1, destination.
- `in_src1`, `in_src2` in 1: mux selects (1 = register, 0 = zero / immediate).
- `in_imm` in DW: immediate.
- `in_wb` in 1: 1 = write result back, 0 = compare/branch only.
- `rd0_addr`, `rd1_addr` out AW: register-file read addresses.
- `alu_src1`, `alu_src2` out 1: mux selects.
- `alu_op` out OP_W: opcode.
- `imm_o` out DW: immediate.
- `alu_f` in DW: ALU result.
- `alu_ovf` in 1: ALU overflow.
- `alu_br` in 1: ALU take_branch.
- `wr_en` out 1: register-file write enable.
- `wr_addr` out AW: write address.
- `wr_data` out DW+1: write data.
- `done` out 1: one-cycle pulse on completion.
- `br_flag` out 1: captured take_branch of the last completed operation.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch all `in_*` fields and go to READ.
  - READ: drive latched addresses, selects, opcode and immediate; the datapath settles combinationally. Go to EXEC.
  - EXEC: capture `alu_f`, `alu_ovf`, `alu_br` into result registers. Go to WRITE.
  - WRITE: if latched `in_wb`=1, `wr_en`=1, `wr_addr`=rd, `wr_data`={ovf, f}. Pulse `done`, update `br_flag`, then go to IDLE.
- Datapath outputs hold their latched values from READ through WRITE. In IDLE they hold the last values.
- `wr_en` is high only in WRITE, for exactly one full cycle. The register file commits on the negedge inside that cycle.
- `in_*` changes outside the accept cycle are ignored.
- Reset (`rst`=0) at any time: state goes to IDLE and all outputs clear immediately.
  - `in_ready`=1; all other outputs 0 (addresses, selects, op, imm, `wr_en`, `wr_addr`, `wr_data`, `done`, `br_flag`).
  - An in-flight operation is discarded and never written.

## Timing
- Accept at edge N. READ in cycle N+1, EXEC in N+2, WRITE/`done` in N+3. `in_ready` returns high in N+4.
- Throughput: one operation per 4 cycles. With `in_valid` held high, accepts occur every 4th edge.
- Read-after-write to the same register in back-to-back operations is safe: the write commits at negedge N+3, before the next READ.
- Results are sampled from the ALU exactly once, at the EXEC→WRITE edge.

## Configuration
- `REGFILE_WB_OVF_TRAP_EN`, defined: when the captured ovf=1, `wr_en` is suppressed in WRITE (`done` still pulses), and sticky output `ovf_err` (1 bit, reset 0) sets and holds until reset.
- Not defined: ovf is written into `wr_data[DW]` and there is no `ovf_err` port.

## Structure
- Shared package `regfile_pkg`: FSM state encoding, the ALU opcode constants (ADD=3'b000, SUB=3'b001, …), `AW`/`DW` defaults.
- One sub-module: `regfile_wb_fsm` (state register, next-state logic and `in_ready`/`wr_en`/`done` decode). Field latches and result registers stay in the top.

## Test plan
- Reset: hold `rst`=0 mid-EXEC of a write op → `wr_en` never asserts, `in_ready`=1, all outputs 0.
- Load via ALU: op=ADD, src1=0, src2=0, imm=40, rd=2, wb=1 → cycle N+3 has `wr_en`=1, `wr_addr`=2, `wr_data`=9'd40.
- Register add: r0=0x55, r1=0xAA, op=ADD, src1=src2=1 → `wr_data`=9'h0FF, `done` pulses once.
- Overflow: operands 0x7F + 0x01 → `wr_data`=9'h180.
  - With `REGFILE_WB_OVF_TRAP_EN`: no write and `ovf_err`=1.
- Compare only: op=SUB, wb=0, equal operands → `wr_en` stays 0, `done` pulses, `br_flag`=`alu_br`.
- Back-to-back: `in_valid` held high for 3 ops → accepts at N, N+4 and N+8; the second op reads the first op's result.
